// File: rtl/lti_sample_scheduler.sv
// lti_sample_scheduler: sample strobe generator, zero-order input hold and valid/ready
// output capture for one LTI state-space core. Optional watchdog: LTI_SCHED_TIMEOUT_EN.
module lti_sample_scheduler #(
  parameter int IW  = 16,
  parameter int OW  = 20,
  parameter int PW  = 16,
  parameter int LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [PW-1:0] period,
  input  logic [IW-1:0] adc_data,
  input  logic          adc_valid,
  output logic [IW-1:0] lti_sig_in,
  output logic          lti_ce_in,
  input  logic [OW-1:0] lti_sig_out,
  input  logic          lti_ce_out,
  output logic [OW-1:0] y_data,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          busy,
  output logic          overrun,
  input  logic          clear_flags,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [PW-1:0] P_MIN      = PW'(LAT + 1);
  localparam logic [PW-1:0] RELOAD_MIN = PW'(LAT);

  state_t        state;
  logic [PW-1:0] cnt;
  logic [PW-1:0] reload;
  logic          done;
  logic          capture;

  // Reload value is P-1 with P clamped so a result can return before the next strobe.
  assign reload  = (period > P_MIN) ? (period - PW'(1)) : RELOAD_MIN;
  assign capture = (state == WAIT) && lti_ce_out;
  assign busy    = (state != IDLE);

`ifdef LTI_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(LAT + 2) + 1;

  logic [WW-1:0] wd;
  logic          wd_expired;

  assign wd_expired = (state == WAIT) && (wd == WW'(LAT)) && !lti_ce_out;
  assign done       = lti_ce_out || wd_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == WAIT) begin
        wd <= wd + WW'(1);
      end else begin
        wd <= '0;
      end
      if (wd_expired) begin
        timeout <= 1'b1;
      end else if (clear_flags) begin
        timeout <= 1'b0;
      end
    end
  end
`else
  assign done    = lti_ce_out;
  assign timeout = 1'b0;
`endif

  // lti_ce_in is registered but always equals (state==RUN && cnt==0); each branch
  // predicts whether the next cycle is that strobe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lti_ce_in <= 1'b0;
    end else begin
      lti_ce_in <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= RUN;
            cnt       <= reload;
            lti_ce_in <= (reload == '0);
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state <= WAIT;
            cnt   <= reload;
          end else if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt       <= cnt - PW'(1);
            lti_ce_in <= (cnt == PW'(1));
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - PW'(1);
          end
          if (done) begin
            if (enable) begin
              state     <= RUN;
              lti_ce_in <= (cnt <= PW'(1));
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lti_sig_in <= '0;
    end else if (adc_valid) begin
      lti_sig_in <= adc_data;
    end
  end

  // A capture overrides a same-cycle transfer so y_valid stays set for the new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_data  <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (capture) begin
        y_data  <= lti_sig_out;
        y_valid <= 1'b1;
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
      end
      if (capture && y_valid && !y_ready) begin
        overrun <= 1'b1;
      end else if (clear_flags) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lti_sample_scheduler.sv
// tb_lti_sample_scheduler: directed stimulus with a LAT-cycle core model and a
// scoreboard queue popped by an independent output monitor.
module tb_lti_sample_scheduler;

  localparam int IW  = 16;
  localparam int OW  = 20;
  localparam int PW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] period = '0;
  logic [IW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic [IW-1:0] lti_sig_in;
  logic          lti_ce_in;
  logic [OW-1:0] lti_sig_out;
  logic          lti_ce_out;
  logic [OW-1:0] y_data;
  logic          y_valid;
  logic          y_ready = 1'b1;
  logic          busy;
  logic          overrun;
  logic          clear_flags = 1'b0;
  logic          timeout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [OW-1:0] expect_q[$];

  logic          core_mute = 1'b0;
  logic [LAT-1:0] pipe_v = '0;
  logic [IW-1:0] pipe_d [LAT] = '{default: '0};

  lti_sample_scheduler #(.IW(IW), .OW(OW), .PW(PW), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .period      (period),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .lti_sig_in  (lti_sig_in),
    .lti_ce_in   (lti_ce_in),
    .lti_sig_out (lti_sig_out),
    .lti_ce_out  (lti_ce_out),
    .y_data      (y_data),
    .y_valid     (y_valid),
    .y_ready     (y_ready),
    .busy        (busy),
    .overrun     (overrun),
    .clear_flags (clear_flags),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Core model: no reset, answers each strobe LAT cycles later with {sample, 4'h3}.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    pipe_v    <= {pipe_v[LAT-2:0], lti_ce_in};
    pipe_d[0] <= lti_sig_in;
    for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end

  assign lti_ce_out  = pipe_v[LAT-1] & ~core_mute;
  assign lti_sig_out = {pipe_d[LAT-1], 4'h3};

  function automatic logic [OW-1:0] core_result(input logic [IW-1:0] s);
    return {s, 4'h3};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [IW-1:0] v);
    adc_data  = v;
    adc_valid = 1'b1;
    tick(1);
    adc_valid = 1'b0;
  endtask

  task automatic waitStrobe(input int limit, output int when);
    when = -1;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if (lti_ce_in) begin
        when = cyc;
        break;
      end
    end
    total++;
    if (when < 0) begin
      bad++;
      $display("[TB] FAIL strobe_wait: no lti_ce_in within %0d cycles", limit);
    end
  endtask

  task automatic countStrobes(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (lti_ce_in) c++;
    end
  endtask

  // Monitor: every accepted output must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && y_valid && y_ready) begin
      if (expect_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL y_xfer_unexpected: got 0x%0h, expected no transfer", y_data);
      end else begin
        checkOutput("y_xfer_data", 32'(y_data), 32'(expect_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin
    int s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, s12, s13, s14, n;

    tick(3);
    checkOutput("rst_ce_in", 32'(lti_ce_in), 0);
    checkOutput("rst_sig_in", 32'(lti_sig_in), 0);
    checkOutput("rst_y_data", 32'(y_data), 0);
    checkOutput("rst_y_valid", 32'(y_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    checkOutput("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;
    tick(2);
    checkOutput("idle_busy", 32'(busy), 0);

    // Periodic sampling at period 10, result 5 cycles after each strobe.
    applyStimulus(16'h0AAA);
    period = 16'd10;
    enable = 1'b1;
    waitStrobe(40, s1);
    expect_q.push_back(core_result(16'h0AAA));
    checkOutput("t1_sig_in", 32'(lti_sig_in), 32'h0AAA);
    checkOutput("t1_busy", 32'(busy), 1);
    tick(4);
    checkOutput("t1_y_valid_early", 32'(y_valid), 0);
    tick(1);
    checkOutput("t1_y_valid_at5", 32'(y_valid), 1);
    checkOutput("t1_y_data", 32'(y_data), 32'(core_result(16'h0AAA)));
    waitStrobe(40, s2);
    expect_q.push_back(core_result(16'h0AAA));
    checkOutput("t1_period_a", 32'(s2 - s1), 10);
    waitStrobe(40, s3);
    expect_q.push_back(core_result(16'h0AAA));
    checkOutput("t1_period_b", 32'(s3 - s2), 10);

    // Short and zero periods clamp to LAT+1.
    period = 16'd2;
    waitStrobe(40, s4);
    expect_q.push_back(core_result(16'h0AAA));
    waitStrobe(40, s5);
    expect_q.push_back(core_result(16'h0AAA));
    checkOutput("t2_clamp_p2", 32'(s5 - s4), 5);
    period = 16'd0;
    waitStrobe(40, s6);
    expect_q.push_back(core_result(16'h0AAA));
    waitStrobe(40, s7);
    expect_q.push_back(core_result(16'h0AAA));
    checkOutput("t2_clamp_p0", 32'(s7 - s6), 5);

    // Two captures with y_ready low: second overwrites, overrun sets, clear drops it.
    period = 16'd10;
    tick(6);
    y_ready = 1'b0;
    applyStimulus(16'h1111);
    waitStrobe(40, s8);
    checkOutput("t3_sig_in_1111", 32'(lti_sig_in), 32'h1111);
    applyStimulus(16'h2222);
    waitStrobe(40, s9);
    expect_q.push_back(core_result(16'h2222));
    checkOutput("t3_period", 32'(s9 - s8), 10);
    tick(4);
    checkOutput("t3_overrun_before", 32'(overrun), 0);
    checkOutput("t3_y_data_first", 32'(y_data), 32'(core_result(16'h1111)));
    checkOutput("t3_y_valid_held", 32'(y_valid), 1);
    tick(1);
    checkOutput("t3_overrun_set", 32'(overrun), 1);
    checkOutput("t3_y_data_second", 32'(y_data), 32'(core_result(16'h2222)));
    checkOutput("t3_y_valid_still", 32'(y_valid), 1);
    clear_flags = 1'b1;
    y_ready = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    checkOutput("t3_overrun_cleared", 32'(overrun), 0);
    checkOutput("t3_y_valid_taken", 32'(y_valid), 0);

    // Enable dropped one cycle after a strobe: that sample completes, then idle.
    waitStrobe(40, s10);
    expect_q.push_back(core_result(16'h2222));
    tick(1);
    enable = 1'b0;
    tick(3);
    checkOutput("t4_busy_in_wait", 32'(busy), 1);
    tick(1);
    checkOutput("t4_busy_done", 32'(busy), 0);
    checkOutput("t4_y_valid", 32'(y_valid), 1);
    countStrobes(25, n);
    checkOutput("t4_no_strobes", 32'(n), 0);
    checkOutput("t4_busy_idle", 32'(busy), 0);

    // Zero-order hold over two strobes, then reset in the middle of WAIT.
    applyStimulus(16'h1234);
    enable = 1'b1;
    waitStrobe(40, s11);
    expect_q.push_back(core_result(16'h1234));
    checkOutput("t5_sig_in_a", 32'(lti_sig_in), 32'h1234);
    waitStrobe(40, s12);
    checkOutput("t5_sig_in_b", 32'(lti_sig_in), 32'h1234);
    checkOutput("t5_period", 32'(s12 - s11), 10);
    tick(2);
    rst = 1'b1;
    enable = 1'b0;
    tick(1);
    checkOutput("t5_rst_ce_in", 32'(lti_ce_in), 0);
    checkOutput("t5_rst_sig_in", 32'(lti_sig_in), 0);
    checkOutput("t5_rst_y_data", 32'(y_data), 0);
    checkOutput("t5_rst_y_valid", 32'(y_valid), 0);
    checkOutput("t5_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick(3);
    checkOutput("t5_late_y_valid", 32'(y_valid), 0);
    checkOutput("t5_late_y_data", 32'(y_data), 0);
    checkOutput("t5_late_busy", 32'(busy), 0);

    // Core never answers.
    core_mute = 1'b1;
    period = 16'd10;
    enable = 1'b1;
`ifdef LTI_SCHED_TIMEOUT_EN
    waitStrobe(40, s13);
    tick(5);
    checkOutput("t6_timeout_before", 32'(timeout), 0);
    tick(1);
    checkOutput("t6_timeout_set", 32'(timeout), 1);
    checkOutput("t6_no_y_valid", 32'(y_valid), 0);
    checkOutput("t6_busy_run", 32'(busy), 1);
    waitStrobe(40, s14);
    checkOutput("t6_on_schedule", 32'(s14 - s13), 10);
    tick(1);
    enable = 1'b0;
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    checkOutput("t6_timeout_cleared", 32'(timeout), 0);
    tick(4);
    checkOutput("t6_timeout_again", 32'(timeout), 1);
    checkOutput("t6_busy_idle", 32'(busy), 0);
`else
    waitStrobe(40, s13);
    countStrobes(20, n);
    checkOutput("t6_stuck_no_strobe", 32'(n), 0);
    checkOutput("t6_timeout_zero", 32'(timeout), 0);
    checkOutput("t6_busy_waiting", 32'(busy), 1);
    checkOutput("t6_no_y_valid", 32'(y_valid), 0);
    enable = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
`endif
    enable = 1'b0;
    core_mute = 1'b0;
    tick(10);
    checkOutput("queue_empty", 32'(expect_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
